mix_sequencer: RTL and testbench
================================

# mix_sequencer

Time-multiplexed controller for the 8-channel audio mix-down path. On each sample tick it snapshots the eight 16-bit signed channel inputs and the per-channel gain/mute configuration. It then steps one shared 19-bit accumulator through the channels, one per clock, and delivers a saturated 16-bit mix plus the full-width sum with a one-cycle valid strobe. It sits between the per-channel audio sources and the audio codec output register.

## Interface
- N_CH, 8, channel count; fixed at 8 in this revision
- ACC_W, 19, accumulator width: 16 + log2(N_CH)
- CLOCK_50  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- sample_tick  in  1  one-cycle pulse requesting a new mix frame
- audio0..audio7  in  16 each  signed two's-complement channel samples
- cfg_we  in  1  configuration write strobe
- cfg_ch  in  3  channel index for the write
- cfg_atten  in  3  right-shift attenuation for the channel, 0..7
- cfg_mute  in  1  mute for the channel
- overrun_clr  in  1  clears the sticky overrun flag
- mix_down  out  16  saturated signed mix; reset 0
- mix_raw  out  19  unsaturated signed sum; reset 0
- mix_valid  out  1  one-cycle strobe; mix outputs are updated on this cycle; reset 0
- clip  out  1  high with mix_valid when saturation occurred; reset 0
- busy  out  1  high whenever state is not IDLE; reset 0
- overrun  out  1  sticky flag: a tick was dropped; reset 0

## Operation
- States: IDLE, ACCUM, DONE.
- IDLE with sample_tick=1:
  - latch audio0..7 into a sample buffer;
  - copy the live cfg registers into the shadow cfg;
  - clear acc and idx; go to ACCUM.
- ACCUM: acc += term(idx); idx++. After idx=7 is added, go to DONE.
- DONE:
  - register mix_raw = acc and mix_down = sat16(acc);
  - assert mix_valid for one cycle, and assert clip if saturation occurred;
  - go to IDLE.
- term(i) = 0 if mute[i]; otherwise sign-extend(sample[i] >>> atten[i]) to 19 bits. The shift is arithmetic.
- Accumulator cannot overflow: the worst case is 8 × ±32768, which fits in 19-bit signed.
- sat16: values above 32767 become 32767 and values below −32768 become −32768; clip=1 in either case.
- cfg_we writes the live registers in any state. Writes affect only frames whose tick is accepted after the write edge.
- sample_tick while in ACCUM or DONE: the tick is dropped and overrun is set. The frame in progress is unaffected.
- If overrun_clr and a dropped tick occur on the same cycle, set wins.
- mix_down and mix_raw hold their value between frames.

## Timing
- Tick sampled at edge E: ACCUM occupies edges E+1..E+8 (channel 0..7 added).
- Edge E+9 enters DONE: outputs update and mix_valid is high during the following cycle.
- Edge E+10 returns to IDLE; a tick at E+10 is accepted.
- Latency from tick to mix_valid: 9 edges. Minimum tick spacing: 10 cycles.
- busy is high from edge E+1 through the cycle ending at E+10.
- Reset mid-frame has immediate effect:
  - FSM returns to IDLE and all outputs return to 0;
  - shadow and live cfg go to atten=0, mute=0;
  - the partial frame is discarded and no mix_valid is produced.

## Structure
- Package mixer_pkg holds:
  - N_CH, SAMPLE_W=16, ACC_W=19;
  - the state enum {IDLE, ACCUM, DONE};
  - the sat16 function.
- Sub-module mix_term, combinational: sample, atten, mute → 19-bit term. It is reused by future multi-bus mixers.
- Top level holds the FSM, idx counter, sample buffer, live/shadow cfg, accumulator, and flags.

## Test plan
- All channels 1000, cfg default, one tick → mix_valid 9 edges later; mix_raw=8000, mix_down=8000, clip=0; busy high for 10 cycles.
- All channels 32767 → mix_raw=262136, mix_down=32767, clip=1. All channels −32768 → mix_raw=−262144, mix_down=−32768, clip=1.
- audio0=−1000, atten0=3, channel 1 muted with audio1=5000, others 0 → mix_raw=−125. The shift must be arithmetic.
- Second tick 4 cycles after the first → overrun=1 and a single mix_valid. Next tick at +10 is accepted. overrun_clr coincident with another dropped tick → overrun stays 1.
- cfg_we (ch0, atten 7) issued during ACCUM → the current frame uses the old atten and the next frame uses atten 7.
- reset asserted at edge E+5 → outputs 0 and no mix_valid; a tick after reset release produces a correct frame.

Source files
------------

// File: rtl/mixer_pkg.sv
// Shared types, widths and saturation helpers for the audio mix-down path.
// Imported by the mixer interface, the term slice and the sequencer top.
package mixer_pkg;

   localparam int N_CH     = 8;
   localparam int SAMPLE_W = 16;
   localparam int ACC_W    = 19;
   localparam int IDX_W    = 3;
   localparam int ATT_W    = 3;

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      DONE
   } state_t;

   typedef struct packed {
      logic [ATT_W-1:0] atten;
      logic             mute;
   } cfg_t;

   localparam logic signed [ACC_W-1:0] SAT_MAX = 19'sd32767;
   localparam logic signed [ACC_W-1:0] SAT_MIN = -19'sd32768;

   function automatic logic sat_hit(
      input logic signed [ACC_W-1:0] v
   );
      return (v > SAT_MAX) || (v < SAT_MIN);
   endfunction

   function automatic logic signed [SAMPLE_W-1:0] sat16(
      input logic signed [ACC_W-1:0] v
   );
      if (v > SAT_MAX)
         return 16'sh7FFF;
      else if (v < SAT_MIN)
         return 16'sh8000;
      else
         return v[SAMPLE_W-1:0];
   endfunction

endpackage

// File: rtl/mix_sequencer_if.sv
// Channel inputs, configuration port and mix outputs of the sequencer.
// master = audio source / host side, slave = sequencer side.
interface mix_sequencer_if;
   import mixer_pkg::*;

   logic                       sample_tick;
   logic signed [SAMPLE_W-1:0] audio0;
   logic signed [SAMPLE_W-1:0] audio1;
   logic signed [SAMPLE_W-1:0] audio2;
   logic signed [SAMPLE_W-1:0] audio3;
   logic signed [SAMPLE_W-1:0] audio4;
   logic signed [SAMPLE_W-1:0] audio5;
   logic signed [SAMPLE_W-1:0] audio6;
   logic signed [SAMPLE_W-1:0] audio7;
   logic                       cfg_we;
   logic [IDX_W-1:0]           cfg_ch;
   logic [ATT_W-1:0]           cfg_atten;
   logic                       cfg_mute;
   logic                       overrun_clr;
   logic signed [SAMPLE_W-1:0] mix_down;
   logic signed [ACC_W-1:0]    mix_raw;
   logic                       mix_valid;
   logic                       clip;
   logic                       busy;
   logic                       overrun;

   modport master (
      output sample_tick,
      output audio0, audio1, audio2, audio3,
      output audio4, audio5, audio6, audio7,
      output cfg_we, cfg_ch, cfg_atten, cfg_mute,
      output overrun_clr,
      input  mix_down, mix_raw, mix_valid,
      input  clip, busy, overrun
   );

   modport slave (
      input  sample_tick,
      input  audio0, audio1, audio2, audio3,
      input  audio4, audio5, audio6, audio7,
      input  cfg_we, cfg_ch, cfg_atten, cfg_mute,
      input  overrun_clr,
      output mix_down, mix_raw, mix_valid,
      output clip, busy, overrun
   );

endinterface

// File: rtl/mix_term.sv
// One channel's contribution: arithmetic attenuation, mute, sign-extend.
// Purely combinational so several mix buses can share it.
module mix_term
   import mixer_pkg::*;
(
   input  logic signed [SAMPLE_W-1:0] i_sample,
   input  logic [ATT_W-1:0]           i_atten,
   input  logic                       i_mute,
   output logic signed [ACC_W-1:0]    o_term
);

   logic signed [SAMPLE_W-1:0] w_shift;

   // >>> on a signed operand keeps negative samples rounding toward -inf
   assign w_shift = i_sample >>> i_atten;

   always_comb begin
      o_term = '0;
      if (!i_mute)
         o_term = {{(ACC_W-SAMPLE_W){w_shift[SAMPLE_W-1]}}, w_shift};
   end

endmodule

// File: rtl/mix_sequencer.sv
// Time-multiplexed 8-channel mixer: snapshot on tick, one channel per
// clock into a shared accumulator, then a saturated result strobe.
module mix_sequencer
   import mixer_pkg::*;
(
   input logic            CLOCK_50,
   input logic            reset,
   mix_sequencer_if.slave bus
);

   state_t                     r_state;
   logic [IDX_W-1:0]           r_idx;
   logic signed [ACC_W-1:0]    r_acc;
   logic signed [SAMPLE_W-1:0] r_smp [N_CH];
   cfg_t                       r_live [N_CH];
   cfg_t                       r_shadow [N_CH];
   logic signed [SAMPLE_W-1:0] r_down;
   logic signed [ACC_W-1:0]    r_raw;
   logic                       r_valid;
   logic                       r_clip;
   logic                       r_busy;
   logic                       r_ovr;

   logic signed [SAMPLE_W-1:0] w_audio [N_CH];
   logic signed [SAMPLE_W-1:0] w_cur_smp;
   cfg_t                       w_cur_cfg;
   logic signed [ACC_W-1:0]    w_term;

   always_comb begin
      w_audio[0] = bus.audio0;
      w_audio[1] = bus.audio1;
      w_audio[2] = bus.audio2;
      w_audio[3] = bus.audio3;
      w_audio[4] = bus.audio4;
      w_audio[5] = bus.audio5;
      w_audio[6] = bus.audio6;
      w_audio[7] = bus.audio7;
   end

   assign w_cur_smp = r_smp[r_idx];
   assign w_cur_cfg = r_shadow[r_idx];

   mix_term u_term (
      .i_sample (w_cur_smp),
      .i_atten  (w_cur_cfg.atten),
      .i_mute   (w_cur_cfg.mute),
      .o_term   (w_term)
   );

   // Live cfg is host-writable at any time; frames only see the shadow copy
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < N_CH; i++)
            r_live[i] <= '0;
      end else if (bus.cfg_we) begin
         r_live[bus.cfg_ch] <= {bus.cfg_atten, bus.cfg_mute};
      end
   end

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_idx   <= '0;
         r_acc   <= '0;
         r_down  <= '0;
         r_raw   <= '0;
         r_valid <= 1'b0;
         r_clip  <= 1'b0;
         r_busy  <= 1'b0;
         r_ovr   <= 1'b0;
         for (int i = 0; i < N_CH; i++) begin
            r_smp[i]    <= '0;
            r_shadow[i] <= '0;
         end
      end else begin
         r_valid <= 1'b0;
         r_clip  <= 1'b0;

         // A dropped tick beats a same-cycle clear
         if (bus.sample_tick && r_state != IDLE)
            r_ovr <= 1'b1;
         else if (bus.overrun_clr)
            r_ovr <= 1'b0;

         unique case (r_state)
            IDLE: begin
               r_busy <= bus.sample_tick;
               if (bus.sample_tick) begin
                  for (int i = 0; i < N_CH; i++) begin
                     r_smp[i]    <= w_audio[i];
                     r_shadow[i] <= r_live[i];
                  end
                  r_acc   <= '0;
                  r_idx   <= '0;
                  r_state <= ACCUM;
               end
            end
            ACCUM: begin
               r_acc <= r_acc + w_term;
               r_idx <= r_idx + 1'b1;
               if (r_idx == IDX_W'(N_CH - 1))
                  r_state <= DONE;
            end
            DONE: begin
               r_raw   <= r_acc;
               r_down  <= sat16(r_acc);
               r_clip  <= sat_hit(r_acc);
               r_valid <= 1'b1;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.mix_down  = r_down;
   assign bus.mix_raw   = r_raw;
   assign bus.mix_valid = r_valid;
   assign bus.clip      = r_clip;
   assign bus.busy      = r_busy;
   assign bus.overrun   = r_ovr;

endmodule

// File: tb/tb_mix_sequencer.sv
// Directed bench for mix_sequencer: vector table of whole frames plus
// hand sequences for overrun, mid-frame cfg writes and mid-frame reset.
module tb_mix_sequencer;

   logic CLOCK_50 = 1'b0;
   logic reset;

   mix_sequencer_if bus();

   mix_sequencer dut (
      .CLOCK_50 (CLOCK_50),
      .reset    (reset),
      .bus      (bus)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   typedef struct {
      logic [7:0][15:0] audio;
      logic [7:0][2:0]  atten;
      logic [7:0]       mute;
      int               raw;
      int               down;
      int               clip;
   } vec_t;

   localparam int NV = 10;
   vec_t vecs [NV];

   int n_run  = 0;
   int n_fail = 0;

   task automatic check(input string nm, input longint got, input longint exp);
      n_run++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, got, exp);
      end
   endtask

   task automatic step();
      @(posedge CLOCK_50);
      #1;
   endtask

   task automatic set_audio(input logic [7:0][15:0] a);
      bus.audio0 = a[0];
      bus.audio1 = a[1];
      bus.audio2 = a[2];
      bus.audio3 = a[3];
      bus.audio4 = a[4];
      bus.audio5 = a[5];
      bus.audio6 = a[6];
      bus.audio7 = a[7];
   endtask

   task automatic write_cfg(input logic [7:0][2:0] at, input logic [7:0] mu);
      for (int ch = 0; ch < 8; ch++) begin
         bus.cfg_we    = 1'b1;
         bus.cfg_ch    = 3'(ch);
         bus.cfg_atten = at[ch];
         bus.cfg_mute  = mu[ch];
         step();
      end
      bus.cfg_we = 1'b0;
   endtask

   task automatic tick();
      bus.sample_tick = 1'b1;
      step();
      bus.sample_tick = 1'b0;
   endtask

   task automatic wait_valid(output int lat);
      lat = -1;
      for (int k = 1; k <= 20; k++) begin
         step();
         if (bus.mix_valid) begin
            lat = k;
            break;
         end
      end
   endtask

   logic [7:0][15:0] a;
   logic [7:0][2:0]  z_at;
   logic [7:0]       z_mu;
   int lat, nv, t1, t2, nb;

   initial begin
      for (int i = 0; i < NV; i++) begin
         vecs[i].audio = '0;
         vecs[i].atten = '0;
         vecs[i].mute  = '0;
         vecs[i].raw   = 0;
         vecs[i].down  = 0;
         vecs[i].clip  = 0;
      end
      for (int c = 0; c < 8; c++) begin
         vecs[0].audio[c] = 16'd1000;
         vecs[1].audio[c] = 16'h7FFF;
         vecs[2].audio[c] = 16'h8000;
         vecs[4].audio[c] = 16'(100 * (c + 1));
         vecs[4].atten[c] = 3'(c);
      end
      vecs[0].raw = 8000;    vecs[0].down = 8000;   vecs[0].clip = 0;
      vecs[1].raw = 262136;  vecs[1].down = 32767;  vecs[1].clip = 1;
      vecs[2].raw = -262144; vecs[2].down = -32768; vecs[2].clip = 1;
      vecs[3].audio[0] = -16'sd1000; vecs[3].atten[0] = 3'd3;
      vecs[3].audio[1] = 16'd5000;   vecs[3].mute[1]  = 1'b1;
      vecs[3].raw = -125;    vecs[3].down = -125;   vecs[3].clip = 0;
      vecs[4].raw = 390;     vecs[4].down = 390;    vecs[4].clip = 0;
      vecs[5].audio[0] = -16'sd7;    vecs[5].atten[0] = 3'd1;
      vecs[5].audio[2] = -16'sd1;    vecs[5].atten[2] = 3'd7;
      vecs[5].audio[3] = 16'h7FFF;   vecs[5].mute[3]  = 1'b1;
      vecs[5].raw = -5;      vecs[5].down = -5;     vecs[5].clip = 0;
      vecs[6].audio[0] = 16'h7FFF;   vecs[6].audio[1] = 16'd1;
      vecs[6].raw = 32768;   vecs[6].down = 32767;  vecs[6].clip = 1;
      vecs[7].audio[0] = 16'h8000;   vecs[7].audio[1] = 16'hFFFF;
      vecs[7].raw = -32769;  vecs[7].down = -32768; vecs[7].clip = 1;
      vecs[8].audio[0] = 16'd16384;  vecs[8].audio[1] = 16'd16383;
      vecs[8].raw = 32767;   vecs[8].down = 32767;  vecs[8].clip = 0;
      vecs[9].audio[0] = 16'hC000;   vecs[9].audio[1] = 16'hC000;
      vecs[9].raw = -32768;  vecs[9].down = -32768; vecs[9].clip = 0;

      z_at = '0;
      z_mu = '0;
      a    = '0;
      reset           = 1'b1;
      bus.sample_tick = 1'b0;
      bus.cfg_we      = 1'b0;
      bus.cfg_ch      = '0;
      bus.cfg_atten   = '0;
      bus.cfg_mute    = 1'b0;
      bus.overrun_clr = 1'b0;
      set_audio(a);
      step();
      step();
      check("rst_down", bus.mix_down, 0);
      check("rst_raw", bus.mix_raw, 0);
      check("rst_valid", bus.mix_valid, 0);
      check("rst_clip", bus.clip, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_overrun", bus.overrun, 0);
      reset = 1'b0;
      step();

      for (int i = 0; i < NV; i++) begin
         write_cfg(vecs[i].atten, vecs[i].mute);
         set_audio(vecs[i].audio);
         tick();
         wait_valid(lat);
         check($sformatf("vec%0d_latency", i), lat, 9);
         check($sformatf("vec%0d_raw", i), bus.mix_raw, vecs[i].raw);
         check($sformatf("vec%0d_down", i), bus.mix_down, vecs[i].down);
         check($sformatf("vec%0d_clip", i), bus.clip, vecs[i].clip);
         step();
         check($sformatf("vec%0d_valid_1cyc", i), bus.mix_valid, 0);
      end

      // busy window: samples at E..E+10 after a tick at edge E
      write_cfg(z_at, z_mu);
      for (int c = 0; c < 8; c++) a[c] = 16'd1000;
      set_audio(a);
      check("busy_idle", bus.busy, 0);
      tick();
      nb = 0;
      for (int k = 0; k < 12; k++) begin
         if (bus.busy) nb++;
         step();
      end
      check("busy_cycles", nb, 10);
      check("busy_after", bus.busy, 0);
      check("hold_raw", bus.mix_raw, 8000);

      // overrun: drop at E+4, accept at E+10
      check("ovr_before", bus.overrun, 0);
      tick();
      nv = 0; t1 = -1; t2 = -1;
      for (int c = 1; c <= 25; c++) begin
         bus.sample_tick = (c == 4 || c == 10);
         step();
         if (bus.mix_valid) begin
            nv++;
            if (t1 < 0) t1 = c;
            else t2 = c;
         end
      end
      bus.sample_tick = 1'b0;
      check("ovr_set", bus.overrun, 1);
      check("ovr_valid_count", nv, 2);
      check("ovr_first_valid", t1, 9);
      check("ovr_second_valid", t2, 19);
      check("ovr_second_raw", bus.mix_raw, 8000);

      // clear coincident with another drop: set wins
      tick();
      step();
      step();
      bus.sample_tick = 1'b1;
      bus.overrun_clr = 1'b1;
      step();
      bus.sample_tick = 1'b0;
      bus.overrun_clr = 1'b0;
      check("ovr_set_wins", bus.overrun, 1);
      for (int k = 0; k < 10; k++) step();
      bus.overrun_clr = 1'b1;
      step();
      bus.overrun_clr = 1'b0;
      check("ovr_cleared", bus.overrun, 0);

      // cfg write mid-frame only affects the next frame
      a = '0;
      a[0] = 16'd1024;
      set_audio(a);
      tick();
      step();
      step();
      bus.cfg_we    = 1'b1;
      bus.cfg_ch    = 3'd0;
      bus.cfg_atten = 3'd7;
      bus.cfg_mute  = 1'b0;
      step();
      bus.cfg_we = 1'b0;
      wait_valid(lat);
      check("cfgmid_latency", lat, 6);
      check("cfgmid_old_raw", bus.mix_raw, 1024);
      step();
      tick();
      wait_valid(lat);
      check("cfgmid_next_latency", lat, 9);
      check("cfgmid_new_raw", bus.mix_raw, 8);
      step();

      // reset at E+5 discards the frame and restores default cfg
      tick();
      for (int k = 0; k < 4; k++) step();
      reset = 1'b1;
      step();
      check("midrst_raw", bus.mix_raw, 0);
      check("midrst_down", bus.mix_down, 0);
      check("midrst_busy", bus.busy, 0);
      check("midrst_valid", bus.mix_valid, 0);
      reset = 1'b0;
      nv = 0;
      for (int k = 0; k < 15; k++) begin
         step();
         if (bus.mix_valid) nv++;
      end
      check("midrst_no_valid", nv, 0);
      tick();
      wait_valid(lat);
      check("postrst_latency", lat, 9);
      check("postrst_raw", bus.mix_raw, 1024);
      check("postrst_clip", bus.clip, 0);
      step();

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
